// File: rtl/local_bus_controller.sv
// Bus cycle sequencer for the 68030 local bus: per-region wait states, DSACK
// port-size encoding, VME acknowledge passthrough and BERR on fault/timeout.
module local_bus_controller #(
   parameter int unsigned ROM_WAIT    = 2,
   parameter int unsigned RAM_WAIT    = 1,
   parameter int unsigned SERIAL_WAIT = 4,
   parameter int unsigned TIMEOUT     = 200,
   parameter logic [1:0]  VME_DSACK   = 2'b00
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       cpu_as,
   input  logic       cpu_ds,
   input  logic       request_rom,
   input  logic       request_ram,
   input  logic       request_serial,
   input  logic       request_vme,
   input  logic       vme_dtack,
   input  logic       vme_berr,
   output logic [1:0] cpu_dsack,
   output logic       cpu_berr,
   output logic       cycle_busy
);

   localparam logic [1:0] ROM_CODE    = 2'b01;
   localparam logic [1:0] RAM_CODE    = 2'b00;
   localparam logic [1:0] SERIAL_CODE = 2'b10;
   localparam logic [1:0] DSACK_IDLE  = 2'b11;

   localparam logic [3:0] ROM_LOAD    = 4'(ROM_WAIT);
   localparam logic [3:0] RAM_LOAD    = 4'(RAM_WAIT);
   localparam logic [3:0] SERIAL_LOAD = 4'(SERIAL_WAIT);
   localparam logic [7:0] TIMEOUT_END = 8'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOCAL_WAIT,
      EXT_WAIT,
      ACK,
      FAULT
   } state_t;

   state_t     state;
   logic [3:0] wait_cnt;
   logic [7:0] timeout_cnt;
   logic [1:0] ack_code;

   logic dtack_meta;
   logic dtack_sync;
   logic berr_meta;
   logic berr_sync;

   // The CPU samples data on DS timing itself, so DS never gates acknowledge.
   logic unused_ds;
   assign unused_ds = cpu_ds;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         dtack_meta <= 1'b1;
         dtack_sync <= 1'b1;
         berr_meta  <= 1'b1;
         berr_sync  <= 1'b1;
      end else begin
         dtack_meta <= vme_dtack;
         dtack_sync <= dtack_meta;
         berr_meta  <= vme_berr;
         berr_sync  <= berr_meta;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state       <= IDLE;
         wait_cnt    <= 4'd0;
         timeout_cnt <= 8'd0;
         ack_code    <= DSACK_IDLE;
         cpu_dsack   <= DSACK_IDLE;
         cpu_berr    <= 1'b1;
         cycle_busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cpu_dsack <= DSACK_IDLE;
               cpu_berr  <= 1'b1;
               if (!cpu_as) begin
                  cycle_busy <= 1'b1;
                  // Several low requests means a decoder fault; rom wins, vme loses.
                  if (!request_rom) begin
                     wait_cnt <= ROM_LOAD;
                     ack_code <= ROM_CODE;
                     state    <= LOCAL_WAIT;
                  end else if (!request_ram) begin
                     wait_cnt <= RAM_LOAD;
                     ack_code <= RAM_CODE;
                     state    <= LOCAL_WAIT;
                  end else if (!request_serial) begin
                     wait_cnt <= SERIAL_LOAD;
                     ack_code <= SERIAL_CODE;
                     state    <= LOCAL_WAIT;
                  end else begin
                     timeout_cnt <= 8'd0;
                     ack_code    <= VME_DSACK;
                     state       <= EXT_WAIT;
                  end
               end else begin
                  cycle_busy <= 1'b0;
               end
            end

            LOCAL_WAIT: begin
               if (cpu_as) begin
                  state      <= IDLE;
                  cycle_busy <= 1'b0;
               end else if (wait_cnt == 4'd0) begin
                  state     <= ACK;
                  cpu_dsack <= ack_code;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end

            EXT_WAIT: begin
               timeout_cnt <= timeout_cnt + 8'd1;
               // Bus error outranks a DTACK arriving on the same clock.
               if (cpu_as) begin
                  state      <= IDLE;
                  cycle_busy <= 1'b0;
               end else if (!berr_sync) begin
                  state    <= FAULT;
                  cpu_berr <= 1'b0;
               end else if (!dtack_sync) begin
                  state     <= ACK;
                  cpu_dsack <= VME_DSACK;
               end else if (timeout_cnt == TIMEOUT_END) begin
                  state    <= FAULT;
                  cpu_berr <= 1'b0;
               end
            end

            ACK: begin
               if (cpu_as) begin
                  state      <= IDLE;
                  cpu_dsack  <= DSACK_IDLE;
                  cycle_busy <= 1'b0;
               end
            end

            FAULT: begin
               cpu_dsack <= DSACK_IDLE;
               if (cpu_as) begin
                  state      <= IDLE;
                  cpu_berr   <= 1'b1;
                  cycle_busy <= 1'b0;
               end
            end

            default: begin
               state      <= IDLE;
               cpu_dsack  <= DSACK_IDLE;
               cpu_berr   <= 1'b1;
               cycle_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_local_bus_controller.sv
// Directed bench for local_bus_controller: wait-state latency, port encodings,
// VME acknowledge, bus error, timeout, abort and asynchronous reset.
module tb_local_bus_controller;

   logic       clk;
   logic       n_reset;
   logic       cpu_as;
   logic       cpu_ds;
   logic       request_rom;
   logic       request_ram;
   logic       request_serial;
   logic       request_vme;
   logic       vme_dtack;
   logic       vme_berr;
   logic [1:0] cpu_dsack;
   logic       cpu_berr;
   logic       cycle_busy;

   int checkCount = 0;
   int errorCount = 0;

   local_bus_controller #(
      .ROM_WAIT(2),
      .RAM_WAIT(1),
      .SERIAL_WAIT(4),
      .TIMEOUT(200),
      .VME_DSACK(2'b00)
   ) dut (
      .clk(clk),
      .n_reset(n_reset),
      .cpu_as(cpu_as),
      .cpu_ds(cpu_ds),
      .request_rom(request_rom),
      .request_ram(request_ram),
      .request_serial(request_serial),
      .request_vme(request_vme),
      .vme_dtack(vme_dtack),
      .vme_berr(vme_berr),
      .cpu_dsack(cpu_dsack),
      .cpu_berr(cpu_berr),
      .cycle_busy(cycle_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Advance n active edges; leaves time 1 unit past the last edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic as_v, input logic rom_v, input logic ram_v,
                                input logic ser_v, input logic vme_v);
      cpu_as         = as_v;
      cpu_ds         = as_v;
      request_rom    = rom_v;
      request_ram    = ram_v;
      request_serial = ser_v;
      request_vme    = vme_v;
   endtask

   initial begin
      n_reset   = 1'b0;
      vme_dtack = 1'b1;
      vme_berr  = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

      // Reset held with a RAM request pending
      tick(3);
      checkOutput("reset_dsack", 8'(cpu_dsack), 8'h3);
      checkOutput("reset_berr", 8'(cpu_berr), 8'h1);
      checkOutput("reset_busy", 8'(cycle_busy), 8'h0);

      n_reset = 1'b1;
      tick(1);
      checkOutput("ram_sample_busy", 8'(cycle_busy), 8'h1);
      tick(1);
      checkOutput("ram_wait_dsack", 8'(cpu_dsack), 8'h3);
      tick(1);
      checkOutput("ram_ack_dsack", 8'(cpu_dsack), 8'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(1);
      checkOutput("ram_end_dsack", 8'(cpu_dsack), 8'h3);
      checkOutput("ram_end_busy", 8'(cycle_busy), 8'h0);
      tick(2);

      // ROM read, 2 wait states, held until AS negates
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      tick(3);
      checkOutput("rom_wait_dsack", 8'(cpu_dsack), 8'h3);
      tick(1);
      checkOutput("rom_ack_dsack", 8'(cpu_dsack), 8'h1);
      tick(3);
      checkOutput("rom_hold_dsack", 8'(cpu_dsack), 8'h1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(1);
      checkOutput("rom_end_dsack", 8'(cpu_dsack), 8'h3);
      tick(2);

      // Serial cycle followed immediately by a RAM cycle
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      tick(5);
      checkOutput("ser_wait_dsack", 8'(cpu_dsack), 8'h3);
      tick(1);
      checkOutput("ser_ack_dsack", 8'(cpu_dsack), 8'h2);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(1);
      checkOutput("ser_end_dsack", 8'(cpu_dsack), 8'h3);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      tick(1);
      checkOutput("b2b_idle_dsack", 8'(cpu_dsack), 8'h3);
      tick(1);
      checkOutput("b2b_wait_dsack", 8'(cpu_dsack), 8'h3);
      tick(1);
      checkOutput("b2b_ack_dsack", 8'(cpu_dsack), 8'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(3);

      // Priority: ROM and RAM both requested, ROM encoding wins
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick(4);
      checkOutput("prio_dsack", 8'(cpu_dsack), 8'h1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(3);

      // VME cycle acknowledged by DTACK after 10 clocks
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick(1);
      checkOutput("vme_busy", 8'(cycle_busy), 8'h1);
      tick(10);
      checkOutput("vme_wait_dsack", 8'(cpu_dsack), 8'h3);
      vme_dtack = 1'b0;
      tick(2);
      checkOutput("vme_sync_dsack", 8'(cpu_dsack), 8'h3);
      tick(1);
      checkOutput("vme_ack_dsack", 8'(cpu_dsack), 8'h0);
      checkOutput("vme_ack_berr", 8'(cpu_berr), 8'h1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      vme_dtack = 1'b1;
      tick(1);
      checkOutput("vme_end_dsack", 8'(cpu_dsack), 8'h3);
      tick(4);

      // VME BERR and DTACK together: bus error wins
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick(6);
      vme_dtack = 1'b0;
      vme_berr  = 1'b0;
      tick(3);
      checkOutput("both_berr", 8'(cpu_berr), 8'h0);
      checkOutput("both_dsack", 8'(cpu_dsack), 8'h3);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      vme_dtack = 1'b1;
      vme_berr  = 1'b1;
      tick(1);
      checkOutput("both_end_berr", 8'(cpu_berr), 8'h1);
      tick(4);

      // VME timeout: BERR exactly 200 clocks after entering EXT_WAIT
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick(1);
      tick(199);
      checkOutput("tmo_early_berr", 8'(cpu_berr), 8'h1);
      tick(1);
      checkOutput("tmo_berr", 8'(cpu_berr), 8'h0);
      checkOutput("tmo_dsack", 8'(cpu_dsack), 8'h3);
      tick(3);
      checkOutput("tmo_hold_berr", 8'(cpu_berr), 8'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(1);
      checkOutput("tmo_end_berr", 8'(cpu_berr), 8'h1);
      checkOutput("tmo_end_busy", 8'(cycle_busy), 8'h0);
      tick(2);

      // Aborted serial cycle: AS negated before the wait states expire
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      tick(3);
      checkOutput("abort_busy", 8'(cycle_busy), 8'h1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(1);
      checkOutput("abort_idle_busy", 8'(cycle_busy), 8'h0);
      for (int i = 0; i < 6; i++) begin
         checkOutput("abort_dsack", 8'(cpu_dsack), 8'h3);
         tick(1);
      end

      // Asynchronous reset while a ROM acknowledge is held
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      tick(4);
      checkOutput("pre_rst_dsack", 8'(cpu_dsack), 8'h1);
      n_reset = 1'b0;
      #1;
      checkOutput("async_rst_dsack", 8'(cpu_dsack), 8'h3);
      checkOutput("async_rst_busy", 8'(cycle_busy), 8'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick(2);
      n_reset = 1'b1;
      tick(2);
      checkOutput("post_rst_dsack", 8'(cpu_dsack), 8'h3);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
